// File: rtl/csr_row_collector.sv
// csr_row_collector: captures completed CSR SpMV row results (two lanes),
// tags each with its row index, buffers them in a first-word-fall-through
// FIFO and streams them out over valid/ready. Tracks frame boundaries and
// raises sticky overflow / protocol-error flags.
//
// Handshake: an output entry transfers on any rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low, the
// head entry (out_row, out_data0/1, out_last) stays stable. The input side
// has no backpressure; a push into a full FIFO is dropped and flagged.
module csr_row_collector #(
   parameter int NUM_ROWS   = 560,
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 16,
   parameter int ROW_W      = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic                          in_zero,
   input  logic [DATA_W-1:0]             in_data0,
   input  logic [DATA_W-1:0]             in_data1,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ROW_W-1:0]              out_row,
   output logic [DATA_W-1:0]             out_data0,
   output logic [DATA_W-1:0]             out_data1,
   output logic                          out_last,
   output logic                          frame_done,
   output logic [15:0]                   frame_count,
   output logic                          overflow,
   output logic                          proto_err,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]      FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);

   // FIFO storage, one array per entry field
   logic [ROW_W-1:0]  mem_row  [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d0   [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d1   [FIFO_DEPTH];
   logic              mem_last [FIFO_DEPTH];

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [ROW_W-1:0]  wr_row;

   logic              push;
   logic              pop;
   logic              full;
   logic              wr_en;
   logic              head_last;
   logic [DATA_W-1:0] push_d0;
   logic [DATA_W-1:0] push_d1;

   // Push/pop qualification; a simultaneous pop frees the slot a full FIFO needs
   always_comb begin
      push      = in_valid || in_zero;
      full      = (level == FULL_LEVEL);
      out_valid = (level != '0);
      pop       = out_valid && out_ready;
      wr_en     = push && (!full || pop);
      // in_valid wins when both are high, so the data lanes are kept
      push_d0   = in_valid ? in_data0 : '0;
      push_d1   = in_valid ? in_data1 : '0;
      head_last = mem_last[rd_ptr];
   end

   // Head entry drives the outputs; zeros when the FIFO is empty
   always_comb begin
      out_row   = '0;
      out_data0 = '0;
      out_data1 = '0;
      out_last  = 1'b0;
      if (out_valid) begin
         out_row   = mem_row[rd_ptr];
         out_data0 = mem_d0[rd_ptr];
         out_data1 = mem_d1[rd_ptr];
         out_last  = head_last;
      end
   end

   // FIFO storage write; contents need no reset because level gates the outputs
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_row[wr_ptr]  <= wr_row;
         mem_d0[wr_ptr]   <= push_d0;
         mem_d1[wr_ptr]   <= push_d1;
         mem_last[wr_ptr] <= (wr_row == LAST_ROW);
      end
   end

   // Pointers, occupancy and the row counter (advances even on dropped pushes)
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         wr_row <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push) wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
      end
   end

   // Frame tracking and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_done  <= 1'b0;
         frame_count <= '0;
         overflow    <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         frame_done <= pop && head_last;
         if (pop && head_last)       frame_count <= frame_count + 16'd1;
         if (push && !wr_en)         overflow    <= 1'b1;
         if (in_valid && in_zero)    proto_err   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_csr_row_collector.sv
// Directed bench for csr_row_collector with a 4-row frame and 16-entry FIFO.
module tb_csr_row_collector;

   localparam int NUM_ROWS   = 4;
   localparam int DATA_W     = 64;
   localparam int FIFO_DEPTH = 16;
   localparam int ROW_W      = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_zero;
   logic [DATA_W-1:0] in_data0;
   logic [DATA_W-1:0] in_data1;
   logic              out_valid;
   logic              out_ready;
   logic [ROW_W-1:0]  out_row;
   logic [DATA_W-1:0] out_data0;
   logic [DATA_W-1:0] out_data1;
   logic              out_last;
   logic              frame_done;
   logic [15:0]       frame_count;
   logic              overflow;
   logic              proto_err;
   logic [4:0]        level;

   int checks = 0;
   int errors = 0;

   csr_row_collector #(
      .NUM_ROWS(NUM_ROWS), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ROW_W(ROW_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_zero(in_zero),
      .in_data0(in_data0), .in_data1(in_data1), .out_valid(out_valid),
      .out_ready(out_ready), .out_row(out_row), .out_data0(out_data0),
      .out_data1(out_data1), .out_last(out_last), .frame_done(frame_done),
      .frame_count(frame_count), .overflow(overflow), .proto_err(proto_err),
      .level(level)
   );

   // Clock
   always #5 clk = ~clk;

   // Advance one edge, then settle away from it
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_zero = 1'b0;
      in_data0 = '0; in_data1 = '0; out_ready = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", out_valid); end
      checks++; if (out_row !== '0) begin errors++; $display("FAIL reset_out_row got %0d exp 0", out_row); end
      checks++; if (out_data0 !== '0 || out_data1 !== '0) begin errors++; $display("FAIL reset_out_data got %0h/%0h exp 0/0", out_data0, out_data1); end
      checks++; if (out_last !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_last_done got %0d/%0d exp 0/0", out_last, frame_done); end
      checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d exp 0", frame_count); end
      checks++; if (overflow !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %0d/%0d exp 0/0", overflow, proto_err); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
   endtask

   task automatic test_single_row();
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data0 = 64'd5; in_data1 = 64'd7;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0d exp 1", out_valid); end
      checks++; if (out_row !== 10'd0 || out_last !== 1'b0) begin errors++; $display("FAIL single_row got %0d last %0d exp 0 last 0", out_row, out_last); end
      checks++; if (out_data0 !== 64'd5 || out_data1 !== 64'd7) begin errors++; $display("FAIL single_data got %0d/%0d exp 5/7", out_data0, out_data1); end
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level_pre got %0d exp 1", level); end
      cyc();
      checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_level_post got %0d valid %0d exp 0 valid 0", level, out_valid); end
   endtask

   task automatic test_zero_row();
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data0 = 64'd1; in_data1 = 64'd2;
      cyc();
      in_valid = 1'b0; in_zero = 1'b1; in_data0 = 64'hFFFF; in_data1 = 64'hFFFF;
      cyc();
      in_zero = 1'b0;
      checks++; if (out_row !== 10'd1) begin errors++; $display("FAIL zero_row got %0d exp 1", out_row); end
      checks++; if (out_data0 !== '0 || out_data1 !== '0) begin errors++; $display("FAIL zero_data got %0h/%0h exp 0/0", out_data0, out_data1); end
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL zero_level got %0d exp 1", level); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1; in_data0 = 64'(100 + i); in_data1 = 64'(i);
         cyc();
      end
      in_valid = 1'b0;
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL bp_level got %0d exp 16", level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %0d exp 1", overflow); end
      checks++; if (out_row !== 10'd0 || out_data0 !== 64'd100) begin errors++; $display("FAIL bp_hold got row %0d data %0d exp row 0 data 100", out_row, out_data0); end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_row !== 10'(i % 4) || out_data0 !== 64'(100 + i) || out_last !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL bp_pop%0d got v%0d row %0d data %0d last %0d exp v1 row %0d data %0d last %0d",
                     i, out_valid, out_row, out_data0, out_last, i % 4, 100 + i, (i % 4 == 3));
         end
         cyc();
      end
      checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got level %0d valid %0d exp 0/0", level, out_valid); end
      checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL bp_frames got %0d exp 4", frame_count); end
      in_valid = 1'b1; in_data0 = 64'd55;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_row !== 10'(17 % NUM_ROWS) || out_data0 !== 64'd55) begin errors++; $display("FAIL bp_next_row got %0d data %0d exp %0d data 55", out_row, out_data0, 17 % NUM_ROWS); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky got %0d exp 1", overflow); end
   endtask

   task automatic test_frame_wrap();
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data0 = 64'd0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_row !== 10'(i % 4) || out_last !== (i == 3) || frame_done !== (i == 4) ||
             frame_count !== ((i == 4) ? 16'd1 : 16'd0) || level !== 5'd1) begin
            errors++;
            $display("FAIL wrap%0d got row %0d last %0d done %0d fc %0d lvl %0d exp row %0d last %0d done %0d fc %0d lvl 1",
                     i, out_row, out_last, frame_done, frame_count, level, i % 4, (i == 3), (i == 4), (i == 4));
         end
         if (i < 4) in_data0 = 64'(i + 1);
         else       in_valid = 1'b0;
         cyc();
      end
      checks++; if (frame_done !== 1'b0 || frame_count !== 16'd1 || level !== 5'd0) begin errors++; $display("FAIL wrap_end got done %0d fc %0d lvl %0d exp 0 1 0", frame_done, frame_count, level); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_zero = 1'b1; in_data0 = 64'd9; in_data1 = 64'd3;
      cyc();
      in_valid = 1'b0;
      checks++; if (level !== 5'd1 || out_data0 !== 64'd9 || out_row !== 10'd0) begin errors++; $display("FAIL simul_entry got lvl %0d data %0d row %0d exp 1 9 0", level, out_data0, out_row); end
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL simul_proto got %0d exp 1", proto_err); end
      cyc();
      in_zero = 1'b0;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      checks++; if (out_row !== 10'd1 || out_data0 !== '0 || level !== 5'd1) begin errors++; $display("FAIL simul_next got row %0d data %0d lvl %0d exp 1 0 1", out_row, out_data0, level); end
      checks++; if (proto_err !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL simul_sticky got %0d/%0d exp 1/0", proto_err, overflow); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_zero = 1'b1; in_data0 = 64'd11;
      cyc();
      in_zero = 1'b0;
      cyc();
      cyc();
      checks++; if (level !== 5'd3 || proto_err !== 1'b1) begin errors++; $display("FAIL mid_pre got lvl %0d proto %0d exp 3 1", level, proto_err); end
      rst = 1'b1;
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_level got lvl %0d valid %0d exp 0 0", level, out_valid); end
      checks++; if (proto_err !== 1'b0 || overflow !== 1'b0 || frame_count !== 16'd0) begin errors++; $display("FAIL mid_flags got %0d/%0d fc %0d exp 0/0 0", proto_err, overflow, frame_count); end
      out_ready = 1'b1;
      in_valid = 1'b1; in_data0 = 64'd21;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_row !== 10'd0 || out_data0 !== 64'd21) begin errors++; $display("FAIL mid_next_row got row %0d data %0d exp 0 21", out_row, out_data0); end
   endtask

   // Test sequence and summary
   initial begin
      test_reset();
      test_single_row();
      test_zero_row();
      test_backpressure();
      test_frame_wrap();
      test_simultaneous();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
